// File: rtl/memory_stage_pkg.sv
// Shared CPU types for the memory stage: controller states and WB source select.
package memory_stage_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      HALTED = 2'd2
   } mem_state_t;

   typedef enum logic [1:0] {
      WS_ALU     = 2'd0,
      WS_LOAD    = 2'd1,
      WS_PC      = 2'd2,
      WS_ALU_ALT = 2'd3
   } write_sig_t;

endpackage

// File: rtl/memory_stage.sv
// MEM stage: issues one registered cache request per memory op and owns the MEM/WB register.
module memory_stage
   import memory_stage_pkg::*;
#(
   parameter int unsigned WORD_W = 32,
   parameter int unsigned RSEL_W = 5
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              flush,
   input  logic [WORD_W-1:0] aluout_i,
   input  logic [WORD_W-1:0] wdat_i,
   input  logic              dREN_i,
   input  logic              dWEN_i,
   input  logic              WEN_i,
   input  logic [RSEL_W-1:0] wsel_i,
   input  logic [1:0]        write_sig_i,
   input  logic [WORD_W-1:0] pcaddr_i,
   input  logic              halt_i,
   output logic              dmemREN,
   output logic              dmemWEN,
   output logic [WORD_W-1:0] dmemaddr,
   output logic [WORD_W-1:0] dmemstore,
   input  logic              dhit,
   input  logic [WORD_W-1:0] dmemload,
   output logic              mem_stall,
   output logic [WORD_W-1:0] wb_dat_o,
   output logic [RSEL_W-1:0] wb_wsel_o,
   output logic              wb_WEN_o,
   output logic              wb_halt_o
);

   mem_state_t        state;
   logic [WORD_W-1:0] wb_result;
   logic              mem_op;

   assign mem_op = dREN_i | dWEN_i;

   always_comb begin
      wb_result = aluout_i;
      case (write_sig_t'(write_sig_i))
         WS_LOAD: wb_result = dmemload;
         WS_PC:   wb_result = pcaddr_i;
         default: wb_result = aluout_i;
      endcase
   end

   // Halt and flush take precedence over a memory op in IDLE, so neither stalls.
   always_comb begin
      mem_stall = 1'b0;
      case (state)
         IDLE:    mem_stall = mem_op & ~halt_i & ~flush;
         ACCESS:  mem_stall = ~dhit;
         default: mem_stall = 1'b0;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         dmemREN   <= 1'b0;
         dmemWEN   <= 1'b0;
         dmemaddr  <= '0;
         dmemstore <= '0;
         wb_dat_o  <= '0;
         wb_wsel_o <= '0;
         wb_WEN_o  <= 1'b0;
         wb_halt_o <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (halt_i) begin
                  wb_halt_o <= 1'b1;
                  wb_WEN_o  <= 1'b0;
                  state     <= HALTED;
               end else if (flush) begin
                  wb_dat_o  <= '0;
                  wb_wsel_o <= '0;
                  wb_WEN_o  <= 1'b0;
                  wb_halt_o <= 1'b0;
               end else if (mem_op) begin
                  dmemaddr  <= aluout_i;
                  dmemstore <= wdat_i;
                  dmemWEN   <= dWEN_i;
                  dmemREN   <= dREN_i & ~dWEN_i;
                  state     <= ACCESS;
               end else begin
                  wb_dat_o  <= wb_result;
                  wb_wsel_o <= wsel_i;
                  wb_WEN_o  <= WEN_i;
                  wb_halt_o <= 1'b0;
               end
            end
            ACCESS: begin
               if (dhit) begin
                  wb_dat_o  <= wb_result;
                  wb_wsel_o <= wsel_i;
                  wb_WEN_o  <= WEN_i;
                  wb_halt_o <= 1'b0;
                  dmemREN   <= 1'b0;
                  dmemWEN   <= 1'b0;
                  state     <= IDLE;
               end
            end
            HALTED: state <= HALTED;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter WORD_W, 32, data/address width.
REQ-002 Parameter RSEL_W, 5, register-select width.
REQ-003 CLK  in  1  sole clock; all state on rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 flush  in  1  bubble request for the WB register.
REQ-006 aluout_i  in  WORD_W  ALU result / memory address from EX/MEM latch.
REQ-007 wdat_i  in  WORD_W  store data.
REQ-008 dREN_i, dWEN_i  in  1 each  load / store request.
REQ-009 WEN_i  in  1  register-file write enable.
REQ-010 wsel_i  in  RSEL_W  destination register.
REQ-011 write_sig_i  in  2  WB source select: 0 ALU, 1 load data, 2 pcaddr_i, 3 ALU.
REQ-012 pcaddr_i  in  WORD_W  link address (PC+4).
REQ-013 halt_i  in  1  halt marker.
REQ-014 dmemREN, dmemWEN  out  1 each  registered cache read/write request.
REQ-015 dmemaddr, dmemstore  out  WORD_W  registered cache address / store data.
REQ-016 dhit  in  1  cache completion, one cycle; dmemload valid same cycle.
REQ-017 dmemload  in  WORD_W  load data.
REQ-018 mem_stall  out  1  combinational; freezes all upstream latches while high.
REQ-019 wb_dat_o, wb_wsel_o, wb_WEN_o, wb_halt_o  out  WORD_W/RSEL_W/1/1  registered MEM/WB outputs.

Function
REQ-020 FSM states IDLE, ACCESS, HALTED shall be implemented.
REQ-021 IDLE, no dREN_i/dWEN_i: WB registers shall load the selected result at the next edge; mem_stall=0; state stays IDLE.
REQ-022 IDLE with dREN_i or dWEN_i: mem_stall=1; next edge enters ACCESS and registers dmemaddr=aluout_i, dmemstore=wdat_i, dmemREN/dmemWEN; WB registers hold.
REQ-023 dREN_i and dWEN_i both high: store wins; dmemREN shall stay 0.
REQ-024 ACCESS without dhit: requests held stable, mem_stall=1, WB registers hold.
REQ-025 ACCESS with dhit: mem_stall=0 that cycle; next edge loads WB registers (load data from dmemload when write_sig_i=1), clears dmemREN/dmemWEN, returns to IDLE.
REQ-026 Minimum memory-op latency: 2 cycles (request cycle + dhit cycle); non-memory ops: 1 cycle.
REQ-027 flush in IDLE: WB registers shall load a bubble (WEN=0, wsel=0, dat=0, halt=0) with priority over input.
REQ-028 flush in ACCESS shall be ignored; the access completes normally.
REQ-029 halt_i in IDLE: next edge sets wb_halt_o=1, wb_WEN_o=0, enters HALTED; halt beats flush.
REQ-030 HALTED: no cache requests, mem_stall=0, all WB outputs frozen until reset.
REQ-031 dhit outside ACCESS shall be ignored.

Reset
REQ-032 RST high shall immediately force state IDLE and every output register (dmemREN, dmemWEN, dmemaddr, dmemstore, wb_*) to 0, including mid-ACCESS.
REQ-033 First edge after RST deasserts shall behave as IDLE.

Structure
REQ-034 State enum and write_sig encodings shall live in the shared CPU types package.
REQ-035 Single module; no sub-module.

Verification
REQ-036 ALU op: aluout_i=0x10, write_sig_i=0, WEN_i=1, wsel_i=3 -> next edge wb_dat_o=0x10, wb_WEN_o=1, wb_wsel_o=3, mem_stall never high.
REQ-037 Load, dhit after 3 wait cycles: aluout_i=0x100, dREN_i=1, dmemload=0xDEADBEEF -> dmemREN=1/dmemaddr=0x100 from cycle 1, mem_stall=1 cycles 0-3, wb_dat_o=0xDEADBEEF after dhit edge.
REQ-038 Store with both enables: dREN_i=dWEN_i=1, wdat_i=0xCAFE -> dmemWEN=1, dmemREN=0, dmemstore=0xCAFE; wb_WEN_o follows WEN_i=0.
REQ-039 flush during ACCESS then in IDLE: load completes with correct data; subsequent IDLE flush yields wb_WEN_o=0.
REQ-040 RST asserted mid-ACCESS: dmemREN drops to 0 without clock edge; state IDLE.
REQ-041 halt_i=1 with flush=1 -> wb_halt_o=1; later dREN_i=1 never raises dmemREN.
